pdm_record_ctrl: RTL and testbench

PDM_RECORD_CTRL -- requirements
Module: pdm_record_ctrl

---
 rtl/pdm_record_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pdm_record_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pdm_record_ctrl.sv
// Record/playback sequencer between a PDM microphone front end, a sample RAM and a PDM output stage.
// Every output is a register, so it changes on the clock edge that samples the triggering input.
module pdm_record_ctrl #(
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_rec,
  input  logic              start_play,
  input  logic              stop,
  input  logic [6:0]        amplitude,
  input  logic              amplitude_valid,
  output logic              mic_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [6:0]        ram_wdata,
  output logic              ram_rd,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [6:0]        ram_rdata,
  output logic [6:0]        play_data,
  output logic              play_valid,
  input  logic              play_ready,
  output logic              busy,
  output logic [ADDR_W:0]   rec_len
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StRec  = 3'd1;
  localparam logic [2:0] StRd   = 3'd2;
  localparam logic [2:0] StWait = 3'd3;
  localparam logic [2:0] StOut  = 3'd4;

  localparam logic [ADDR_W:0] MaxLen  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LastIdx = MaxLen - 1'b1;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W:0]   wr_cnt_q, wr_cnt_d;
  logic [ADDR_W:0]   rd_cnt_q, rd_cnt_d;
  logic [ADDR_W:0]   rec_len_q, rec_len_d;
  logic              mic_en_q, mic_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_waddr_q, ram_waddr_d;
  logic [6:0]        ram_wdata_q, ram_wdata_d;
  logic              ram_rd_q, ram_rd_d;
  logic [ADDR_W-1:0] ram_raddr_q, ram_raddr_d;
  logic [6:0]        play_data_q, play_data_d;
  logic              play_valid_q, play_valid_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    rec_len_d    = rec_len_q;
    ram_we_d     = 1'b0;
    ram_waddr_d  = ram_waddr_q;
    ram_wdata_d  = ram_wdata_q;
    ram_raddr_d  = ram_raddr_q;
    play_data_d  = play_data_q;
    play_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_rec) begin
          state_d  = StRec;
          wr_cnt_d = '0;
        end else if (start_play && (rec_len_q != '0)) begin
          state_d  = StRd;
          rd_cnt_d = '0;
        end
      end
      StRec: begin
        if (amplitude_valid) begin
          ram_we_d    = 1'b1;
          ram_waddr_d = wr_cnt_q[ADDR_W-1:0];
          ram_wdata_d = amplitude;
          wr_cnt_d    = wr_cnt_q + 1'b1;
        end
        // A coincident write still lands, so wr_cnt_d already includes it.
        if (amplitude_valid && (wr_cnt_q == LastIdx)) begin
          rec_len_d = MaxLen;
          state_d   = StIdle;
        end else if (stop) begin
          rec_len_d = wr_cnt_d;
          state_d   = StIdle;
        end
      end
      StRd: begin
        state_d = stop ? StIdle : StWait;
      end
      StWait: begin
        if (stop) begin
          state_d = StIdle;
        end else begin
          play_data_d  = ram_rdata;
          play_valid_d = 1'b1;
          state_d      = StOut;
        end
      end
      StOut: begin
        if (play_ready) begin
          rd_cnt_d = rd_cnt_q + 1'b1;
          state_d  = (stop || (rd_cnt_d == rec_len_q)) ? StIdle : StRd;
        end else if (stop) begin
          state_d = StIdle;
        end else begin
          play_valid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Strobes that simply mirror the next state are registered from it.
    mic_en_d = (state_d == StRec);
    ram_rd_d = (state_d == StRd);
    busy_d   = (state_d != StIdle);
    if (state_d == StRd) begin
      ram_raddr_d = rd_cnt_d[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      rec_len_q    <= '0;
      mic_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_waddr_q  <= '0;
      ram_wdata_q  <= '0;
      ram_rd_q     <= 1'b0;
      ram_raddr_q  <= '0;
      play_data_q  <= '0;
      play_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      rec_len_q    <= rec_len_d;
      mic_en_q     <= mic_en_d;
      ram_we_q     <= ram_we_d;
      ram_waddr_q  <= ram_waddr_d;
      ram_wdata_q  <= ram_wdata_d;
      ram_rd_q     <= ram_rd_d;
      ram_raddr_q  <= ram_raddr_d;
      play_data_q  <= play_data_d;
      play_valid_q <= play_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign mic_en     = mic_en_q;
  assign ram_we     = ram_we_q;
  assign ram_waddr  = ram_waddr_q;
  assign ram_wdata  = ram_wdata_q;
  assign ram_rd     = ram_rd_q;
  assign ram_raddr  = ram_raddr_q;
  assign play_data  = play_data_q;
  assign play_valid = play_valid_q;
  assign busy       = busy_q;
  assign rec_len    = rec_len_q;

endmodule

// File: tb/tb_pdm_record_ctrl.sv
// Directed bench for pdm_record_ctrl at ADDR_W=4 with a behavioural one-cycle-latency sample RAM.
module tb_pdm_record_ctrl;

  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_rec, start_play, stop;
  logic [6:0]    amplitude;
  logic          amplitude_valid;
  logic          mic_en, ram_we, ram_rd;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [6:0]    ram_wdata, ram_rdata, play_data;
  logic          play_valid, play_ready, busy;
  logic [AW:0]   rec_len;

  logic [6:0] mem [16];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pdm_record_ctrl #(.ADDR_W(AW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_rec       (start_rec),
    .start_play      (start_play),
    .stop            (stop),
    .amplitude       (amplitude),
    .amplitude_valid (amplitude_valid),
    .mic_en          (mic_en),
    .ram_we          (ram_we),
    .ram_waddr       (ram_waddr),
    .ram_wdata       (ram_wdata),
    .ram_rd          (ram_rd),
    .ram_raddr       (ram_raddr),
    .ram_rdata       (ram_rdata),
    .play_data       (play_data),
    .play_valid      (play_valid),
    .play_ready      (play_ready),
    .busy            (busy),
    .rec_len         (rec_len)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    if (ram_rd) ram_rdata <= mem[ram_raddr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; start_rec = 1'b0; start_play = 1'b0; stop = 1'b0;
    amplitude = '0; amplitude_valid = 1'b0; play_ready = 1'b0; ram_rdata = '0;
    step(); step();
    check("rst_busy", 32'(busy), 0);
    check("rst_mic_en", 32'(mic_en), 0);
    check("rst_ram_we", 32'(ram_we), 0);
    check("rst_ram_rd", 32'(ram_rd), 0);
    check("rst_play_valid", 32'(play_valid), 0);
    check("rst_rec_len", 32'(rec_len), 0);
    check("rst_play_data", 32'(play_data), 0);
    #3 rst_n = 1'b1;

    // start_play with nothing recorded is ignored
    step();
    start_play = 1'b1; step(); start_play = 1'b0;
    check("play_empty_busy", 32'(busy), 0);
    check("play_empty_rd", 32'(ram_rd), 0);

    // start_rec wins over a simultaneous start_play
    start_rec = 1'b1; start_play = 1'b1; step(); start_rec = 1'b0; start_play = 1'b0;
    check("conflict_mic_en", 32'(mic_en), 1);
    check("conflict_busy", 32'(busy), 1);
    check("conflict_ram_rd", 32'(ram_rd), 0);

    // stop together with a valid keeps the write and counts it
    amplitude = 7'd33; amplitude_valid = 1'b1; stop = 1'b1; step();
    amplitude_valid = 1'b0; stop = 1'b0;
    check("stopv_we", 32'(ram_we), 1);
    check("stopv_waddr", 32'(ram_waddr), 0);
    check("stopv_wdata", 32'(ram_wdata), 33);
    check("stopv_rec_len", 32'(rec_len), 1);
    check("stopv_busy", 32'(busy), 0);

    // record 10..14 then stop; start_rec keeps the old rec_len
    start_rec = 1'b1; step(); start_rec = 1'b0;
    check("rec_keep_len", 32'(rec_len), 1);
    check("rec_mic_en", 32'(mic_en), 1);
    for (int i = 0; i < 5; i++) begin
      amplitude = 7'(10 + i); amplitude_valid = 1'b1; step(); amplitude_valid = 1'b0;
      check("rec_we", 32'(ram_we), 1);
      check("rec_waddr", 32'(ram_waddr), 32'(i));
      check("rec_wdata", 32'(ram_wdata), 32'(10 + i));
      step();
      check("rec_we_gap", 32'(ram_we), 0);
    end
    start_play = 1'b1; step(); start_play = 1'b0;
    check("rec_ignore_play", 32'(ram_rd), 0);
    stop = 1'b1; step(); stop = 1'b0;
    check("rec_stop_len", 32'(rec_len), 5);
    check("rec_stop_busy", 32'(busy), 0);
    check("rec_stop_mic", 32'(mic_en), 0);

    // playback with play_ready high: one sample every 3 cycles
    play_ready = 1'b1;
    start_play = 1'b1; step(); start_play = 1'b0;
    check("play_rd", 32'(ram_rd), 1);
    check("play_raddr0", 32'(ram_raddr), 0);
    step(); step();
    check("play_valid0", 32'(play_valid), 1);
    check("play_data0", 32'(play_data), 10);
    for (int k = 1; k < 5; k++) begin
      step();
      check("play_gap_valid", 32'(play_valid), 0);
      check("play_raddr", 32'(ram_raddr), 32'(k));
      step(); step();
      check("play_valid", 32'(play_valid), 1);
      check("play_data", 32'(play_data), 32'(10 + k));
    end
    step();
    check("play_end_busy", 32'(busy), 0);
    check("play_end_valid", 32'(play_valid), 0);

    // backpressure holds the first sample, then stop drops it
    play_ready = 1'b0;
    start_play = 1'b1; step(); start_play = 1'b0;
    step(); step();
    for (int k = 0; k < 7; k++) begin
      check("bp_valid", 32'(play_valid), 1);
      check("bp_data", 32'(play_data), 10);
      step();
    end
    stop = 1'b1; step(); stop = 1'b0;
    check("bp_stop_valid", 32'(play_valid), 0);
    check("bp_stop_busy", 32'(busy), 0);
    check("bp_stop_len", 32'(rec_len), 5);

    // fill: 20 back-to-back valids, only 16 are written
    start_rec = 1'b1; step(); start_rec = 1'b0;
    for (int i = 0; i < 20; i++) begin
      amplitude = 7'(40 + i); amplitude_valid = 1'b1; step();
      if (i < 16) begin
        check("fill_we", 32'(ram_we), 1);
        check("fill_waddr", 32'(ram_waddr), 32'(i));
      end else begin
        check("fill_we_ignored", 32'(ram_we), 0);
      end
      if (i == 15) begin
        check("fill_len", 32'(rec_len), 16);
        check("fill_busy", 32'(busy), 0);
        check("fill_wdata", 32'(ram_wdata), 55);
      end
    end
    amplitude_valid = 1'b0;
    check("fill_len_after", 32'(rec_len), 16);

    // asynchronous reset during the 3rd recorded sample
    start_rec = 1'b1; step(); start_rec = 1'b0;
    for (int i = 0; i < 2; i++) begin
      amplitude = 7'(20 + i); amplitude_valid = 1'b1; step();
    end
    amplitude = 7'd22;
    #2 rst_n = 1'b0;
    #1;
    check("arst_we", 32'(ram_we), 0);
    check("arst_mic_en", 32'(mic_en), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_waddr", 32'(ram_waddr), 0);
    check("arst_wdata", 32'(ram_wdata), 0);
    check("arst_rec_len", 32'(rec_len), 0);
    step();
    check("arst_edge_we", 32'(ram_we), 0);
    check("arst_edge_rd", 32'(ram_rd), 0);
    amplitude_valid = 1'b0;
    #4 rst_n = 1'b1;
    start_play = 1'b1; step(); start_play = 1'b0;
    check("rel_play_ignored", 32'(busy), 0);
    check("rel_rec_len", 32'(rec_len), 0);
    start_rec = 1'b1; step(); start_rec = 1'b0;
    check("rel_rec_mic", 32'(mic_en), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
